// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared encodings, widths and decode helper for the datapath controller
//
// Holds the alu16 opcodes, instruction field encodings, the controller state
// enum and the instruction decode function. alu16 imports this package too so
// the opcodes stay in agreement.
package datapath_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int ALU_OP_W   = 5;
    localparam int OP_W       = 4;
    localparam int EXT_W      = 4;
    localparam int IMM8_W     = 8;

    // alu16 opcodes
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_CMP = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_MOV = 5'd6;

    // op field value that selects the register-register group (ext picks the op)
    localparam logic [OP_W-1:0] OP_RR = 4'b0000;

    // Operation codes: used as ext for register-register ops and as op for
    // immediate ops. LUI exists only in the immediate form.
    localparam logic [OP_W-1:0] CODE_ADD = 4'b0101;
    localparam logic [OP_W-1:0] CODE_SUB = 4'b1001;
    localparam logic [OP_W-1:0] CODE_CMP = 4'b1011;
    localparam logic [OP_W-1:0] CODE_AND = 4'b0001;
    localparam logic [OP_W-1:0] CODE_OR  = 4'b0010;
    localparam logic [OP_W-1:0] CODE_XOR = 4'b0011;
    localparam logic [OP_W-1:0] CODE_MOV = 4'b1101;
    localparam logic [OP_W-1:0] CODE_LUI = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'd0,
        EXT_SIGN  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_sel_e;

    typedef struct packed {
        logic                legal;
        logic [ALU_OP_W-1:0] alu_op;
        logic                b_sel;
        ext_sel_e            ext_sel;
        logic                flags;
        logic                write;
    } decode_t;

    function automatic decode_t decode_instr(input logic [DATA_W-1:0] instr);
        decode_t          d;
        logic [OP_W-1:0]  op;
        logic [OP_W-1:0]  code;
        logic             is_imm;
        op     = instr[15:12];
        is_imm = (op != OP_RR);
        // Both instruction groups share one code table; only the field differs.
        code   = is_imm ? op : instr[7:4];
        d         = '0;
        d.ext_sel = EXT_ZERO;
        d.b_sel   = is_imm;
        case (code)
            CODE_ADD: begin d.legal = 1'b1; d.alu_op = ALU_ADD; d.ext_sel = EXT_SIGN; d.flags = 1'b1; d.write = 1'b1; end
            CODE_SUB: begin d.legal = 1'b1; d.alu_op = ALU_SUB; d.ext_sel = EXT_SIGN; d.flags = 1'b1; d.write = 1'b1; end
            CODE_CMP: begin d.legal = 1'b1; d.alu_op = ALU_CMP; d.ext_sel = EXT_SIGN; d.flags = 1'b1; end
            CODE_AND: begin d.legal = 1'b1; d.alu_op = ALU_AND; d.flags = 1'b1; d.write = 1'b1; end
            CODE_OR:  begin d.legal = 1'b1; d.alu_op = ALU_OR;  d.flags = 1'b1; d.write = 1'b1; end
            CODE_XOR: begin d.legal = 1'b1; d.alu_op = ALU_XOR; d.flags = 1'b1; d.write = 1'b1; end
            CODE_MOV: begin d.legal = 1'b1; d.alu_op = ALU_MOV; d.write = 1'b1; end
            // LUI is MOV of an upper-shifted immediate; ext=1111 in the RR group is illegal
            CODE_LUI: begin d.legal = is_imm; d.alu_op = ALU_MOV; d.ext_sel = EXT_UPPER; d.write = is_imm; end
            default:  d.legal = 1'b0;
        endcase
        if (!d.legal) begin
            d.alu_op = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - instruction handshake and regfile/ALU control bundle
//
// master: the controller (accepts instr, drives datapath control).
// slave : the instruction source plus regfile/alu16 side.
// Signals: instr, instr_valid, instr_ready, we, w_addr, ra_addr, rb_addr,
//          alu_op, b_sel, imm, flags_en, busy, illegal, retired.
interface datapath_ctrl_if;

    logic [datapath_pkg::DATA_W-1:0]     instr;
    logic                                instr_valid;
    logic                                instr_ready;
    logic                                we;
    logic [datapath_pkg::REG_ADDR_W-1:0] w_addr;
    logic [datapath_pkg::REG_ADDR_W-1:0] ra_addr;
    logic [datapath_pkg::REG_ADDR_W-1:0] rb_addr;
    logic [datapath_pkg::ALU_OP_W-1:0]   alu_op;
    logic                                b_sel;
    logic [datapath_pkg::DATA_W-1:0]     imm;
    logic                                flags_en;
    logic                                busy;
    logic                                illegal;
    logic                                retired;

    modport master (
        input  instr, instr_valid,
        output instr_ready, we, w_addr, ra_addr, rb_addr, alu_op, b_sel,
               imm, flags_en, busy, illegal, retired
    );

    modport slave (
        output instr, instr_valid,
        input  instr_ready, we, w_addr, ra_addr, rb_addr, alu_op, b_sel,
               imm, flags_en, busy, illegal, retired
    );

endinterface

// File: rtl/datapath_ctrl_imm_ext.sv
// rtl/datapath_ctrl_imm_ext.sv - imm8 to 16-bit immediate extension
//
// Ports: imm8 (8-bit field), sel (zero / sign / upper), imm (16-bit result).
module imm_ext
    import datapath_pkg::*;
(
    input  logic [IMM8_W-1:0] imm8,
    input  ext_sel_e          sel,
    output logic [DATA_W-1:0] imm
);

    always_comb begin
        imm = '0;
        case (sel)
            EXT_SIGN:  imm = {{(DATA_W-IMM8_W){imm8[IMM8_W-1]}}, imm8};
            EXT_UPPER: imm = {imm8, {(DATA_W-IMM8_W){1'b0}}};
            default:   imm = {{(DATA_W-IMM8_W){1'b0}}, imm8};
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle control FSM for the regfile + alu16 datapath
//
// Ports: clk, rst (sync, active-high), bus (datapath_ctrl_if.master):
//   instruction valid/ready handshake in, regfile addresses, write enable,
//   alu_op, b_sel/imm, flags_en, busy, illegal and retired pulses out.
// Sequence per instruction: IDLE -> DECODE -> EXEC -> WB -> IDLE.
module datapath_ctrl
    import datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    datapath_ctrl_if.master bus
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] instr_q;
    decode_t           dec;
    logic [DATA_W-1:0] imm_w;

    // Decode only from the latched word so outputs never follow live instr.
    always_comb begin
        dec = decode_instr(instr_q);
    end

    imm_ext u_imm_ext (
        .imm8 (instr_q[IMM8_W-1:0]),
        .sel  (dec.ext_sel),
        .imm  (imm_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.instr_valid) begin
                instr_q <= bus.instr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.instr_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_IDLE;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.we          = 1'b0;
        bus.w_addr      = '0;
        bus.ra_addr     = '0;
        bus.rb_addr     = '0;
        bus.alu_op      = '0;
        bus.b_sel       = 1'b0;
        bus.imm         = '0;
        bus.flags_en    = 1'b0;
        bus.busy        = 1'b0;
        bus.illegal     = 1'b0;
        bus.retired     = 1'b0;
        if (state_q == ST_IDLE) begin
            bus.instr_ready = 1'b1;
        end else begin
            // Operand selection is held steady from DECODE through WB.
            bus.busy    = 1'b1;
            bus.ra_addr = instr_q[11:8];
            bus.rb_addr = instr_q[3:0];
            bus.alu_op  = dec.alu_op;
            bus.b_sel   = dec.b_sel;
            bus.imm     = imm_w;
            case (state_q)
                ST_DECODE: bus.illegal = ~dec.legal;
                ST_EXEC:   bus.flags_en = dec.flags;
                ST_WB: begin
                    bus.w_addr  = instr_q[11:8];
                    bus.we      = dec.write;
                    bus.retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - self-checking bench for datapath_ctrl with a behavioural regfile/ALU
module tb_datapath_ctrl;

    logic        clk;
    logic        rst;
    logic        rf_clr;
    int          n_cmp;
    int          n_fail;
    int          we_count;
    logic [15:0] rf [16];
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] alu_y;

    datapath_ctrl_if dp ();

    datapath_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for regfile + alu16, driven by the controller outputs.
    always_comb begin
        op_a  = rf[dp.ra_addr];
        op_b  = dp.b_sel ? dp.imm : rf[dp.rb_addr];
        alu_y = 16'h0000;
        case (dp.alu_op)
            5'd0: alu_y = op_a + op_b;
            5'd1: alu_y = op_a - op_b;
            5'd2: alu_y = op_a & op_b;
            5'd3: alu_y = op_a | op_b;
            5'd4: alu_y = op_a ^ op_b;
            5'd5: alu_y = op_a - op_b;
            5'd6: alu_y = op_b;
            default: alu_y = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
            we_count <= 0;
        end else if (dp.we) begin
            rf[dp.w_addr] <= alu_y;
            we_count      <= we_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction while the controller is idle; returns in DECODE.
    task automatic send(input logic [15:0] ins);
        dp.instr       = ins;
        dp.instr_valid = 1'b1;
        step();
        dp.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        rf_clr         = 1'b1;
        dp.instr       = 16'h0000;
        dp.instr_valid = 1'b0;
        step();
        step();
        n_cmp++; if (dp.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", dp.instr_ready); end
        n_cmp++; if ({dp.we, dp.flags_en, dp.illegal, dp.retired, dp.busy} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl got=%b exp=00000", {dp.we, dp.flags_en, dp.illegal, dp.retired, dp.busy}); end
        n_cmp++; if ({dp.w_addr, dp.ra_addr, dp.rb_addr} !== 12'h000) begin n_fail++; $display("FAIL reset_addr got=%h exp=000", {dp.w_addr, dp.ra_addr, dp.rb_addr}); end
        rst    = 1'b0;
        rf_clr = 1'b0;
        step();
    endtask

    task automatic test_movi();
        send(16'hD105);
        n_cmp++; if (dp.b_sel !== 1'b1) begin n_fail++; $display("FAIL movi_bsel got=%b exp=1", dp.b_sel); end
        n_cmp++; if (dp.imm !== 16'h0005) begin n_fail++; $display("FAIL movi_imm got=%h exp=0005", dp.imm); end
        n_cmp++; if (dp.alu_op !== 5'd6) begin n_fail++; $display("FAIL movi_aluop got=%0d exp=6", dp.alu_op); end
        n_cmp++; if ({dp.instr_ready, dp.busy} !== 2'b01) begin n_fail++; $display("FAIL movi_busy got=%b exp=01", {dp.instr_ready, dp.busy}); end
        step();
        n_cmp++; if (dp.flags_en !== 1'b0) begin n_fail++; $display("FAIL movi_flags got=%b exp=0", dp.flags_en); end
        step();
        n_cmp++; if ({dp.we, dp.w_addr, dp.retired} !== 6'b1_0001_1) begin n_fail++; $display("FAIL movi_wb got=%b exp=100011", {dp.we, dp.w_addr, dp.retired}); end
        step();
        n_cmp++; if (dp.instr_ready !== 1'b1) begin n_fail++; $display("FAIL movi_ready got=%b exp=1", dp.instr_ready); end
        n_cmp++; if (rf[1] !== 16'h0005) begin n_fail++; $display("FAIL movi_r1 got=%h exp=0005", rf[1]); end
    endtask

    task automatic test_add_sub();
        send(16'hD203);
        step(); step(); step();
        n_cmp++; if (rf[2] !== 16'h0003) begin n_fail++; $display("FAIL movi_r2 got=%h exp=0003", rf[2]); end
        send(16'h0152);
        n_cmp++; if ({dp.ra_addr, dp.rb_addr} !== 8'h12) begin n_fail++; $display("FAIL add_addr got=%h exp=12", {dp.ra_addr, dp.rb_addr}); end
        n_cmp++; if ({dp.b_sel, dp.alu_op} !== 6'd0) begin n_fail++; $display("FAIL add_op got=%h exp=00", {dp.b_sel, dp.alu_op}); end
        step();
        n_cmp++; if ({dp.flags_en, dp.we} !== 2'b10) begin n_fail++; $display("FAIL add_exec got=%b exp=10", {dp.flags_en, dp.we}); end
        step();
        n_cmp++; if ({dp.flags_en, dp.we} !== 2'b01) begin n_fail++; $display("FAIL add_wb got=%b exp=01", {dp.flags_en, dp.we}); end
        step();
        n_cmp++; if (rf[1] !== 16'h0008) begin n_fail++; $display("FAIL add_r1 got=%h exp=0008", rf[1]); end
        send(16'h0192);
        n_cmp++; if (dp.alu_op !== 5'd1) begin n_fail++; $display("FAIL sub_aluop got=%0d exp=1", dp.alu_op); end
        step(); step(); step();
        n_cmp++; if (rf[1] !== 16'h0005) begin n_fail++; $display("FAIL sub_r1 got=%h exp=0005", rf[1]); end
    endtask

    task automatic test_cmpi_lui();
        int we_before;
        we_before = we_count;
        send(16'hB1FF);
        n_cmp++; if (dp.imm !== 16'hFFFF) begin n_fail++; $display("FAIL cmpi_imm got=%h exp=ffff", dp.imm); end
        n_cmp++; if (dp.alu_op !== 5'd5) begin n_fail++; $display("FAIL cmpi_aluop got=%0d exp=5", dp.alu_op); end
        step();
        n_cmp++; if (dp.flags_en !== 1'b1) begin n_fail++; $display("FAIL cmpi_flags got=%b exp=1", dp.flags_en); end
        step();
        n_cmp++; if ({dp.we, dp.retired} !== 2'b01) begin n_fail++; $display("FAIL cmpi_wb got=%b exp=01", {dp.we, dp.retired}); end
        step();
        n_cmp++; if (we_count !== we_before) begin n_fail++; $display("FAIL cmpi_nowrite got=%0d exp=%0d", we_count, we_before); end
        n_cmp++; if (dp.retired !== 1'b0) begin n_fail++; $display("FAIL cmpi_pulse got=%b exp=0", dp.retired); end
        send(16'hF312);
        n_cmp++; if (dp.imm !== 16'h1200) begin n_fail++; $display("FAIL lui_imm got=%h exp=1200", dp.imm); end
        n_cmp++; if (dp.alu_op !== 5'd6) begin n_fail++; $display("FAIL lui_aluop got=%0d exp=6", dp.alu_op); end
        step(); step(); step();
        n_cmp++; if (rf[3] !== 16'h1200) begin n_fail++; $display("FAIL lui_r3 got=%h exp=1200", rf[3]); end
    endtask

    task automatic test_illegal();
        int we_before;
        we_before = we_count;
        send(16'h0E00);
        n_cmp++; if ({dp.illegal, dp.we, dp.flags_en} !== 3'b100) begin n_fail++; $display("FAIL ill_decode got=%b exp=100", {dp.illegal, dp.we, dp.flags_en}); end
        step();
        n_cmp++; if ({dp.instr_ready, dp.illegal, dp.busy} !== 3'b100) begin n_fail++; $display("FAIL ill_idle got=%b exp=100", {dp.instr_ready, dp.illegal, dp.busy}); end
        send(16'h00F1);
        n_cmp++; if (dp.illegal !== 1'b1) begin n_fail++; $display("FAIL ill_rr_lui got=%b exp=1", dp.illegal); end
        step();
        n_cmp++; if (we_count !== we_before) begin n_fail++; $display("FAIL ill_nowrite got=%0d exp=%0d", we_count, we_before); end
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int accepts;
        int cyc;
        accepts        = 0;
        cyc            = 0;
        dp.instr       = 16'hD405;
        dp.instr_valid = 1'b1;
        while (accepts < 2 && cyc < 20) begin
            if (dp.instr_ready) begin
                acc[accepts] = cyc;
                accepts++;
            end
            step();
            cyc++;
            if (accepts == 1) dp.instr = 16'hD507;
            if (accepts == 2) dp.instr_valid = 1'b0;
        end
        dp.instr_valid = 1'b0;
        n_cmp++; if (accepts !== 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=2", accepts); end
        n_cmp++; if (accepts == 2 && acc[1] - acc[0] !== 4) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=4", acc[1] - acc[0]); end
        step(); step(); step();
        n_cmp++; if (rf[4] !== 16'h0005) begin n_fail++; $display("FAIL b2b_r4 got=%h exp=0005", rf[4]); end
        n_cmp++; if (rf[5] !== 16'h0007) begin n_fail++; $display("FAIL b2b_r5 got=%h exp=0007", rf[5]); end
    endtask

    task automatic test_reset_mid();
        int we_before;
        we_before = we_count;
        send(16'h0152);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({dp.instr_ready, dp.busy, dp.we, dp.retired} !== 4'b1000) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=1000", {dp.instr_ready, dp.busy, dp.we, dp.retired}); end
        step(); step(); step();
        n_cmp++; if (we_count !== we_before) begin n_fail++; $display("FAIL rstmid_nowrite got=%0d exp=%0d", we_count, we_before); end
        n_cmp++; if (rf[1] !== 16'h0005) begin n_fail++; $display("FAIL rstmid_r1 got=%h exp=0005", rf[1]); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_movi();
        test_add_sub();
        test_cmpi_lui();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
